alu_seq: RTL

- Parametrised, clocked successor to the 8-bit combinational ALU used by the CPU datapath.
- Keeps the FORWARD, ADD, AND and OR opcodes, with a registered result.
- Adds a ZERO flag and iterative MULT, SLL, SRA and ROR operations.
- Uses a START/BUSY/DONE handshake so the control unit can stall on multi-cycle ops.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_iter_unit.sv | 71 +++++++
 rtl/alu_seq.sv | 112 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode and state definitions shared by the sequential ALU
package alu_pkg;

    localparam logic [2:0] OP_FWD  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_MULT = 3'b100;
    localparam logic [2:0] OP_SLL  = 3'b101;
    localparam logic [2:0] OP_SRA  = 3'b110;
    localparam logic [2:0] OP_ROR  = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic is_shift(input logic [2:0] op);
        return (op == OP_SLL) || (op == OP_SRA) || (op == OP_ROR);
    endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// rtl/alu_iter_unit.sv - bit-serial multiply and shift datapath with down-counter
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int SHW = $clog2(WIDTH),
    localparam int CW  = SHW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [CW-1:0]    cnt_init,
    output logic             last_step,
    output logic [WIDTH-1:0] result
);

    logic [2:0]       op_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] step_val;

    // step_val is the value after the step taken on the coming edge, so the
    // top can capture it directly on the final step.
    always_comb begin
        step_val = shreg;
        case (op_q)
            OP_MULT: step_val = acc + (mplier[0] ? mcand : '0);
            OP_SLL:  step_val = {shreg[WIDTH-2:0], 1'b0};
            OP_SRA:  step_val = {shreg[WIDTH-1], shreg[WIDTH-1:1]};
            OP_ROR:  step_val = {shreg[0], shreg[WIDTH-1:1]};
            default: step_val = shreg;
        endcase
    end

    assign result    = step_val;
    assign last_step = (cnt == CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= OP_FWD;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            shreg  <= '0;
            cnt    <= '0;
        end else if (load) begin
            op_q   <= op;
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            shreg  <= a;
            cnt    <= cnt_init;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
            if (op_q == OP_MULT) begin
                acc    <= step_val;
                mcand  <= {mcand[WIDTH-2:0], 1'b0};
                mplier <= {1'b0, mplier[WIDTH-1:1]};
            end else begin
                shreg <= step_val;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - clocked ALU with single-cycle logic ops and iterative mult/shift
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [2:0]       SELECT,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    output logic [WIDTH-1:0] RESULT,
    output logic             ZERO,
    output logic             BUSY,
    output logic             DONE
);

    localparam int CW = SHW + 1;

    state_t           state;
    state_t           state_next;
    logic [SHW-1:0]   amt;
    logic             multi;
    logic [CW-1:0]    cnt_init;
    logic [WIDTH-1:0] single_val;
    logic             load;
    logic             wr_en;
    logic [WIDTH-1:0] wr_val;
    logic             last_step;
    logic [WIDTH-1:0] iter_result;

    assign amt      = DATA2[SHW-1:0];
    assign multi    = (SELECT == OP_MULT) || (is_shift(SELECT) && (amt != '0));
    assign cnt_init = (SELECT == OP_MULT) ? CW'(WIDTH) : {1'b0, amt};
    assign BUSY     = (state == ST_RUN);

    // A shift by zero completes immediately and returns DATA1 unchanged.
    always_comb begin
        single_val = DATA1;
        case (SELECT)
            OP_FWD:  single_val = DATA2;
            OP_ADD:  single_val = DATA1 + DATA2;
            OP_AND:  single_val = DATA1 & DATA2;
            OP_OR:   single_val = DATA1 | DATA2;
            default: single_val = DATA1;
        endcase
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        wr_en      = 1'b0;
        wr_val     = single_val;
        case (state)
            ST_IDLE: begin
                if (START) begin
                    if (multi) begin
                        load       = 1'b1;
                        state_next = ST_RUN;
                    end else begin
                        wr_en = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (last_step) begin
                    wr_en      = 1'b1;
                    wr_val     = iter_result;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            RESULT <= '0;
            ZERO   <= 1'b1;
            DONE   <= 1'b0;
        end else begin
            DONE <= wr_en;
            if (wr_en) begin
                RESULT <= wr_val;
                ZERO   <= (wr_val == '0);
            end
        end
    end

    alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
        .clk       (CLK),
        .rst       (RESET),
        .load      (load),
        .op        (SELECT),
        .a         (DATA1),
        .b         (DATA2),
        .cnt_init  (cnt_init),
        .last_step (last_step),
        .result    (iter_result)
    );

endmodule
